// File: rtl/button_arbiter.sv
// -----------------------------------------------------------------------------
// button_arbiter
//
// Purpose:
//   Front end for the board push-buttons. Each raw button is synchronized,
//   then debounced against a shared tick prescaler. Every debounced 0->1
//   transition becomes one queued event (one pending bit per button). Pending
//   events are handed to a single consumer over a valid/ready handshake,
//   granted round-robin starting after the last accepted button.
//
// Ports:
//   clk         in   system clock (single domain)
//   reset       in   asynchronous, active-high reset
//   btn_in      in   raw asynchronous button levels   [NUM_BTN]
//   cmd_ready   in   consumer accepts the offered command
//   cmd_valid   out  a command is being offered
//   cmd_id      out  index of the button behind the offered command [ID_W]
//   btn_level   out  debounced button levels         [NUM_BTN]
//   drop_pulse  out  one-cycle pulse: a press was lost because that button
//                    already had an event pending
// -----------------------------------------------------------------------------
module button_arbiter #(
  parameter int NUM_BTN      = 4,
  parameter int ID_W         = 2,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic               cmd_ready,
  output logic               cmd_valid,
  output logic [ID_W-1:0]    cmd_id,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               drop_pulse
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W   = $clog2(STABLE_TICKS + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] sync1_q, sync1_d;
  logic [NUM_BTN-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared debounce prescaler: one tick every TICK_DIV cycles
  // ---------------------------------------------------------------------------
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick;

  always_comb begin
    tick    = (presc_q == PRESC_W'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-button debounce. cnt counts consecutive ticks on which the synced
  // input disagrees with the debounced level; the level flips on the tick
  // that would bring the count to STABLE_TICKS.
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_level_q;
  logic [NUM_BTN-1:0] btn_level_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_debounce
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             level_q, level_d;

      always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (tick) begin
          if (sync2_q[gi] == level_q) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_W'(STABLE_TICKS - 1)) begin
            level_d = ~level_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q   <= '0;
          level_q <= 1'b0;
        end else begin
          cnt_q   <= cnt_d;
          level_q <= level_d;
        end
      end

      assign btn_level_q[gi] = level_q;
      assign btn_level_d[gi] = level_d;
    end
  endgenerate

  // A press is the edge on which the debounced level goes 0->1.
  logic [NUM_BTN-1:0] press;
  assign press = btn_level_d & ~btn_level_q;

  // ---------------------------------------------------------------------------
  // Round-robin selection: first pending bit at or after last_grant+1,
  // wrapping modulo NUM_BTN.
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    sel_idx;
  logic               sel_found;

  always_comb begin
    cand      = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      cand = ID_W'((int'(last_grant_q) + k) % NUM_BTN);
      if (!sel_found && pending_q[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter FSM
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [ID_W-1:0]    cmd_id_q, cmd_id_d;
  logic               drop_q, drop_d;
  logic [NUM_BTN-1:0] grant_clr;

  always_comb begin
    state_d      = state_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_id_d     = cmd_id_q;
    last_grant_d = last_grant_q;
    grant_clr    = '0;

    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          cmd_id_d    = sel_idx;
          cmd_valid_d = 1'b1;
          grant_clr   = NUM_BTN'(1) << sel_idx;
          state_d     = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (cmd_ready) begin
          cmd_valid_d  = 1'b0;
          last_grant_d = cmd_id_q;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase

    // Clear-then-set: a press landing on the grant edge of the same button
    // stays queued. A press is only lost when its bit is pending and survives.
    pending_d = (pending_q & ~grant_clr) | press;
    drop_d    = |(press & pending_q & ~grant_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_valid_q  <= 1'b0;
      cmd_id_q     <= '0;
      last_grant_q <= ID_W'(NUM_BTN - 1);
      pending_q    <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_id_q     <= cmd_id_d;
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      drop_q       <= drop_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_id     = cmd_id_q;
  assign btn_level  = btn_level_q;
  assign drop_pulse = drop_q;

endmodule
